// File: rtl/lsu_mem_port_if.sv
// Request/response and memory-side bus of the load/store unit.
// The slave modport is the LSU; the master modport is the pipeline plus data memory.
interface lsu_mem_port_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit in front of a word-addressed data memory. Sub-word stores are
// done as read-modify-write; loads are lane-extracted and sign/zero-extended.
module lsu_mem_port #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_WORDS     = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_port_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    old_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_q;

  logic                     accept;
  logic                     f3_ok;
  logic                     misalign;
  logic                     oob;
  logic                     req_err;
  logic                     sub_word_q;
  logic [ADDRESS_WIDTH-1:0] req_widx;
  logic [DATA_WIDTH-1:0]    load_ext;
  logic [DATA_WIDTH-1:0]    merged;
  logic [7:0]               rd_byte;
  logic [15:0]              rd_half;

  assign bus.req_ready = rst_n && (state_q == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_widx      = {2'b00, bus.req_addr[ADDRESS_WIDTH-1:2]};
  assign sub_word_q    = (f3_q[1:0] != 2'b10);

  // Accept-time legality: funct3 decode, alignment and word-index range.
  always_comb begin
    f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.req_we;
      default:                f3_ok = 1'b0;
    endcase
    misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
    oob      = (req_widx >= ADDRESS_WIDTH'(MEM_WORDS));
    req_err  = !f3_ok || misalign || oob;
  end

  // Load lane extraction and extension from the memory read word.
  always_comb begin
    rd_byte  = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    load_ext = bus.mem_rd;
    case (f3_q[1:0])
      2'b00:   load_ext = f3_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = f3_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = bus.mem_rd;
    endcase
  end

  // Store word: old word with the addressed lane replaced, or the full store data for SW.
  always_comb begin
    merged = old_q;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Next-state selection for the request sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                                   state_d = S_RESP;
          else if (bus.req_we && bus.req_funct3 == 3'b010) state_d = S_WRITE;
          else                                           state_d = S_READ;
        end
      end
      S_READ:  state_d = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        if (req_err) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
      if (state_q == S_READ) begin
        if (we_q && sub_word_q) begin
          old_q <= bus.mem_rd;
        end else begin
          rdata_q <= load_ext;
          err_q   <= 1'b0;
        end
      end
      if (state_q == S_WRITE) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Memory strobe and data are derived from state so reset drops them at once.
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.mem_wd     = (state_q == S_WRITE) ? merged : '0;
  assign bus.mem_a      = {2'b00, addr_q[ADDRESS_WIDTH-1:2]};
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small behavioural word memory.
module tb_lsu_mem_port;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  lsu_mem_port_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) ifc ();

  lsu_mem_port #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(4096)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  logic [31:0] mem [0:15];

  assign ifc.mem_rd = mem[ifc.mem_a[3:0]];

  always @(posedge clk) begin
    if (ifc.mem_we) mem[ifc.mem_a[3:0]] <= ifc.mem_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    logic [31:0] exp_word4;
  } vec_t;

  vec_t vecs [0:16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    int wes;
    bit seen;
    k = 0; wes = 0; seen = 0;
    @(negedge clk);
    while (!ifc.req_ready && k < 20) begin @(negedge clk); k++; end
    check($sformatf("vec%0d_ready", idx), {31'b0, ifc.req_ready}, 32'd1);
    ifc.req_valid  = 1'b1;
    ifc.req_we     = v.we;
    ifc.req_funct3 = v.f3;
    ifc.req_addr   = v.addr;
    ifc.req_wdata  = v.wdata;
    @(posedge clk);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    k = 0;
    while (k < 10) begin
      if (ifc.mem_we) wes++;
      if (ifc.resp_valid) begin seen = 1; break; end
      @(negedge clk);
      k++;
    end
    check($sformatf("vec%0d_resp_seen", idx), {31'b0, seen}, 32'd1);
    check($sformatf("vec%0d_latency", idx), k + 1, v.exp_lat);
    check($sformatf("vec%0d_rdata", idx), ifc.resp_rdata, v.exp_rdata);
    check($sformatf("vec%0d_err", idx), {31'b0, ifc.resp_err}, {31'b0, v.exp_err});
    check($sformatf("vec%0d_mem_a", idx), ifc.mem_a, {2'b00, v.addr[31:2]});
    check($sformatf("vec%0d_we_cycles", idx), wes, v.exp_wes);
    @(negedge clk);
    check($sformatf("vec%0d_resp_pulse", idx), {31'b0, ifc.resp_valid}, 32'd0);
    check($sformatf("vec%0d_word4", idx), mem[4], v.exp_word4);
  endtask

  initial begin
    int lows;
    int k;
    bit any_resp;
    logic [2:0]  bf3   [0:2];
    logic        bwe   [0:2];
    logic [31:0] bdata [0:2];
    int          blow  [0:2];

    total = 0; passed = 0;
    for (int unsigned i = 0; i < 16; i++) mem[i] = '0;

    //            we   f3      addr          wdata         rdata         err lat wes word4
    vecs[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'b000, 32'h13,   32'h000000A5, 32'h0,        1'b0, 3, 1, 32'hA5ADBEEF};
    vecs[3]  = '{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFA5, 1'b0, 2, 0, 32'hA5ADBEEF};
    vecs[4]  = '{1'b0, 3'b100, 32'h13,   32'h0,        32'h000000A5, 1'b0, 2, 0, 32'hA5ADBEEF};
    vecs[5]  = '{1'b0, 3'b000, 32'h11,   32'h0,        32'hFFFFFFBE, 1'b0, 2, 0, 32'hA5ADBEEF};
    vecs[6]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 3'b001, 32'h12,   32'h00001234, 32'h0,        1'b0, 3, 1, 32'h1234BEEF};
    vecs[8]  = '{1'b0, 3'b001, 32'h12,   32'h0,        32'h00001234, 1'b0, 2, 0, 32'h1234BEEF};
    vecs[9]  = '{1'b0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 32'h1234BEEF};
    vecs[10] = '{1'b0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 1'b0, 2, 0, 32'h1234BEEF};
    vecs[11] = '{1'b0, 3'b010, 32'h11,   32'h0,        32'h0,        1'b1, 1, 0, 32'h1234BEEF};
    vecs[12] = '{1'b1, 3'b001, 32'h13,   32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h1234BEEF};
    vecs[13] = '{1'b1, 3'b010, 32'h4000, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h1234BEEF};
    vecs[14] = '{1'b1, 3'b100, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h1234BEEF};
    vecs[15] = '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1, 1, 0, 32'h1234BEEF};
    vecs[16] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'h1234BEEF, 1'b0, 2, 0, 32'h1234BEEF};

    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_funct3 = '0;
    ifc.req_addr = '0; ifc.req_wdata = '0;

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_ready",      {31'b0, ifc.req_ready},  32'd0);
    check("rst_resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    check("rst_rdata",      ifc.resp_rdata,          32'd0);
    check("rst_err",        {31'b0, ifc.resp_err},   32'd0);
    check("rst_mem_we",     {31'b0, ifc.mem_we},     32'd0);
    check("rst_mem_a",      ifc.mem_a,               32'd0);
    check("rst_mem_wd",     ifc.mem_wd,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'b0, ifc.req_ready}, 32'd1);

    for (int unsigned i = 0; i < 17; i++) run_vec(int'(i), vecs[i]);

    // Back-to-back with req_valid held high: SB, LW, SW to 0x10
    bwe[0] = 1'b1; bf3[0] = 3'b000; bdata[0] = 32'h00000077; blow[0] = 3;
    bwe[1] = 1'b0; bf3[1] = 3'b010; bdata[1] = 32'h0;        blow[1] = 2;
    bwe[2] = 1'b1; bf3[2] = 3'b010; bdata[2] = 32'hCAFEF00D; blow[2] = 2;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 32'h10;
    for (int unsigned r = 0; r < 3; r++) begin
      ifc.req_we = bwe[r]; ifc.req_funct3 = bf3[r]; ifc.req_wdata = bdata[r];
      check($sformatf("b2b%0d_ready_at_issue", r), {31'b0, ifc.req_ready}, 32'd1);
      @(negedge clk);
      lows = 0;
      while (!ifc.req_ready && lows < 20) begin lows++; @(negedge clk); end
      check($sformatf("b2b%0d_ready_low_cycles", r), lows, blow[r]);
    end
    ifc.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_word4", mem[4], 32'hCAFEF00D);

    // Reset during the WRITE cycle of an SB
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_we = 1'b1; ifc.req_funct3 = 3'b000;
    ifc.req_addr = 32'h10; ifc.req_wdata = 32'h0000005A;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    k = 0;
    while (!ifc.mem_we && k < 10) begin @(negedge clk); k++; end
    check("rstmid_in_write", {31'b0, ifc.mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_we_drop", {31'b0, ifc.mem_we}, 32'd0);
    @(posedge clk);
    #1;
    check("rstmid_word4",      mem[4],                  32'hCAFEF00D);
    check("rstmid_resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    check("rstmid_rdata",      ifc.resp_rdata,          32'd0);
    check("rstmid_err",        {31'b0, ifc.resp_err},   32'd0);
    check("rstmid_mem_a",      ifc.mem_a,               32'd0);
    check("rstmid_mem_wd",     ifc.mem_wd,              32'd0);
    check("rstmid_ready",      {31'b0, ifc.req_ready},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid_ready_rel", {31'b0, ifc.req_ready}, 32'd1);
    any_resp = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ifc.resp_valid || ifc.mem_we) any_resp = 1;
    end
    check("rstmid_no_resp", {31'b0, any_resp}, 32'd0);
    check("rstmid_word4_after", mem[4], 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting directly upstream of the word-addressed data memory in the memory stage of the pipelined RV32 core. It accepts one byte-addressed load or store request at a time and converts the byte address to a word index. Sub-word stores (SB/SH) are carried out as a read-modify-write, because the memory has a single word-wide write enable. Load data is aligned and sign- or zero-extended. Misaligned and out-of-range accesses are rejected with an error flag, and the memory is not touched.

## Interface
- ADDRESS_WIDTH, 32, request and memory address width
- DATA_WIDTH, 32, data width; only 32 is supported
- MEM_WORDS, 4096, number of words in the downstream memory; word indices at or above this value are out of range

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data; B uses bits [7:0], H uses bits [15:0]
- resp_valid  out  1  one-cycle completion pulse; issued for both loads and stores
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and for errors
- resp_err  out  1  access was misaligned, out of range, or had an illegal funct3
- mem_a  out  ADDRESS_WIDTH  word index = {2'b00, addr[31:2]}
- mem_wd  out  DATA_WIDTH  write data
- mem_we  out  1  write enable; the memory writes on the rising edge
- mem_rd  in  DATA_WIDTH  combinational read data returned for mem_a

## Operation
- States: IDLE, READ, WRITE, RESP.
- req_ready = rst_n && (state == IDLE). A handshake is req_valid && req_ready; all request fields are latched on it.
- Error check runs at accept time:
  - H/HU with addr[0] = 1 is an error.
  - W with addr[1:0] != 0 is an error.
  - Word index >= MEM_WORDS is an error.
  - funct3 not in {000, 001, 010, 100, 101} is an error, as is a store with funct3 100 or 101.
- Transitions:
  - Error: IDLE -> RESP. resp_err = 1, resp_rdata = 0, no memory access.
  - Load: IDLE -> READ -> RESP. In READ, mem_a is driven and the extracted, extended mem_rd is registered into resp_rdata.
  - SW: IDLE -> WRITE -> RESP. In WRITE, mem_we = 1 and mem_wd = req_wdata.
  - SB/SH: IDLE -> READ -> WRITE -> RESP.
    - READ registers the old word.
    - WRITE drives mem_we = 1 and mem_wd = old word with the byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) replaced.
  - RESP: resp_valid = 1 for exactly one cycle, then -> IDLE.
- Load extraction:
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- mem_we is high only in WRITE. mem_wd is 0 outside WRITE. mem_a holds the latched word index, and is 0 after reset.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_a 0, mem_wd 0. req_ready is 0 while rst_n is low and 1 after release.
- Latency from the accept edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- Throughput: one request per latency+1 cycles. req_ready is low from the cycle after accept through RESP inclusive.
- resp_rdata and resp_err are valid only while resp_valid = 1. They hold their values until the next RESP.
- req_valid held high while req_ready = 0 is ignored. The request is accepted on the first IDLE cycle.
- Reset mid-operation: rst_n low forces IDLE immediately.
  - mem_we drops asynchronously, so no write happens on the following edge.
  - No resp_valid is produced for the aborted request.
  - A partially done RMW leaves memory unchanged.
- mem_we is asserted for exactly one cycle per successful store.

## Test plan
- SW 0x10 with 0xDEADBEEF, then LW 0x10:
  - During the store, mem_a = 4 and mem_we is high for one cycle.
  - The load returns resp_rdata 0xDEADBEEF, resp_err 0, with resp_valid 2 cycles after its accept.
- Starting from word 4 = 0xDEADBEEF, SB 0x13 with 0x000000A5:
  - Word becomes 0xA5ADBEEF, resp_valid 3 cycles after accept.
  - LB 0x13 returns 0xFFFFFFA5; LBU 0x13 returns 0x000000A5.
- Starting from 0xDEADBEEF, SH 0x12 with 0x00001234:
  - Word becomes 0x1234BEEF.
  - LH 0x12 returns 0x00001234; LH 0x10 returns 0xFFFFBEEF; LHU 0x10 returns 0x0000BEEF.
- Each of LW 0x11, SH 0x13, SW 0x4000 (word index 4096) and a store with funct3 100:
  - resp_err 1, resp_rdata 0, resp_valid 1 cycle after accept.
  - mem_we never asserted; word 4 unchanged.
- req_valid held high across back-to-back SB, LW, SW requests: each is accepted only when req_ready = 1, with exactly 3, 2 and 2 cycles of req_ready low respectively.
- rst_n pulsed low during WRITE of an SB to 0x10:
  - mem_we falls immediately and word 4 is unchanged.
  - No resp_valid is produced.
  - All outputs hold their reset values; req_ready returns to 1 on release.
